s444_evt_observer: RTL and testbench
====================================

// Module: s444_evt_observer
// PURPOSE
//   Downstream stage of the s444 controller. Samples its six state outputs
//   {G107,G108,G118,G119,G167,G168} every enabled cycle and detects each change
//   of the vector. Every change becomes an event {old code, new code, dwell
//   cycles}, queued in a small FIFO and drained over a valid/ready interface
//   by the logging/check layer.
// PARAMETERS
//   DWW    4   width of dwell counter (saturates at 2**DWW-1)
//   DEPTH  4   event FIFO depth (power of two, >=2)
//   DCW    8   width of dropped-event counter (saturating)
// PORTS
//   CK        in   1     clock, rising edge
//   RSTN      in   1     reset, synchronous, active-low
//   IN_EN     in   1     sample qualifier; 0 = ignore IN_VEC this cycle
//   IN_VEC    in   6     {G107,G108,G118,G119,G167,G168} from s444
//   EV_VALID  out  1     event available at FIFO head
//   EV_READY  in   1     consumer accepts head when EV_VALID&EV_READY
//   EV_OLD    out  6     vector value before the change
//   EV_NEW    out  6     vector value after the change
//   EV_DWELL  out  DWW   enabled cycles EV_OLD was held (saturated)
//   OVF       out  1     sticky: at least one event dropped since reset
//   DROP_CNT  out  DCW   number of dropped events (saturating)
// BEHAVIOUR
//   - Reset (RSTN=0 at a CK edge): FIFO emptied, EV_VALID=0, EV_OLD/EV_NEW/
//     EV_DWELL=0, OVF=0, DROP_CNT=0, ARMED=0, CUR=0, DWELL=0. Reset overrides
//     all else; events in flight are discarded, including a same-cycle pop.
//   - IN_EN=0: CUR, DWELL, ARMED frozen; FIFO still drains.
//   - IN_EN=1, ARMED=0: CUR<=IN_VEC, DWELL<=1, ARMED<=1, no event.
//   - IN_EN=1, ARMED=1, IN_VEC==CUR: DWELL<=min(DWELL+1, 2**DWW-1).
//   - IN_EN=1, ARMED=1, IN_VEC!=CUR: push {CUR, IN_VEC, DWELL};
//     CUR<=IN_VEC, DWELL<=1.
//   - Latency: event sampled at edge N is on EV_* with EV_VALID=1 after edge
//     N+1 when FIFO was empty (one registered stage, no bypass).
//   - Handshake: EV_* stable while EV_VALID=1 and EV_READY=0; pop on
//     EV_VALID&EV_READY; EV_READY with EV_VALID=0 has no effect.
//   - Full + push + pop same cycle: both occur, no drop, count unchanged.
//   - Full + push, no pop: event dropped, OVF<=1, DROP_CNT<=min(DROP_CNT+1,
//     2**DCW-1). FIFO contents untouched.
//   - Empty + push + pop: pop ignored (EV_VALID was 0); count becomes 1.
//   - Pointers wrap modulo DEPTH; count held in log2(DEPTH)+1 bits.
//   - EV_* outputs show 0 when EV_VALID=0.
// STRUCTURE
//   Package s444_evt_pkg: typedef struct packed {logic [5:0] old_v, new_v;
//   logic [DWW-1:0] dwell;} evt_t; localparam VEC_W=6.
//   Sub-module s444_evt_fifo: synchronous FIFO of evt_t with push/pop/full/
//   empty, same reset rule. Top holds change detect, dwell, drop logic.
// TESTING
//   1 RSTN=0 2 cycles, IN_VEC=6'h3F -> EV_VALID=0, OVF=0, DROP_CNT=0.
//   2 EN=1, hold 6'h05 x3 then 6'h0A, READY=1 -> one event
//     OLD=05 NEW=0A DWELL=3, valid one cycle after the change edge.
//   3 DWW=4, hold 6'h11 x20 then 6'h22 -> DWELL=15 (saturated).
//   4 READY=0, 5 distinct changes -> 4 queued in order, OVF=1,
//     DROP_CNT=1; READY=1 drains 4 events then EV_VALID=0.
//   5 FIFO full, change + READY=1 same cycle -> no drop, 4 entries remain.
//   6 2 events queued, RSTN=0 1 cycle -> EV_VALID=0; next sample only
//     re-arms (no event); IN_EN=0 gap -> DWELL unchanged across gap.

Source files
------------

// File: rtl/s444_evt_pkg.sv
// s444_evt_pkg: shared types and helpers for the s444 event observer.
//   VEC_W     width of the observed s444 state vector {G107,G108,G118,G119,G167,G168}
//   DWW       width of the dwell counter carried in every event
//   evt_t     one change event {old vector, new vector, dwell cycles}
//   dwell_inc saturating increment of a dwell count
package s444_evt_pkg;

  localparam int VEC_W = 6;
  localparam int DWW   = 4;
  localparam int EVT_W = 2 * VEC_W + DWW;

  typedef struct packed {
    logic [VEC_W-1:0] old_v;
    logic [VEC_W-1:0] new_v;
    logic [DWW-1:0]   dwell;
  } evt_t;

  // Saturating +1: an all-ones dwell stays all-ones.
  function automatic logic [DWW-1:0] dwell_inc(input logic [DWW-1:0] d);
    logic [DWW-1:0] r;
    if (d == {DWW{1'b1}}) begin
      r = d;
    end else begin
      r = d + DWW'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/s444_evt_fifo.sv
// s444_evt_fifo: synchronous FIFO of evt_t records.
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset; empties the FIFO, overrides push/pop
//   push      in   write push_data (accepted when not full, or when full and popping)
//   push_data in   record to write
//   pop       in   remove the head (ignored when empty)
//   head      out  record at the head, all zeros while empty
//   full      out  DEPTH entries held
//   empty     out  no entries held
module s444_evt_fifo
  import s444_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  evt_t          mem_q [DEPTH];
  evt_t          mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == {(AW+1){1'b0}});

  // When full, a push is only taken together with a pop: the slot being
  // vacated by the head is the one the write pointer already points at.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Head record, zeroed while nothing is stored.
  always_comb begin
    if (empty) begin
      head = evt_t'({EVT_W{1'b0}});
    end else begin
      head = mem_q[rd_ptr_q];
    end
  end

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/s444_evt_observer.sv
// s444_evt_observer: watches the s444 state vector, turns every change into an
// event {old, new, dwell} and queues it for a valid/ready consumer.
//   CK        in   clock, rising edge
//   RSTN      in   synchronous active-low reset
//   IN_EN     in   sample qualifier; 0 freezes the observer state
//   IN_VEC    in   {G107,G108,G118,G119,G167,G168}
//   EV_VALID  out  event available at FIFO head
//   EV_READY  in   consumer accepts head when EV_VALID & EV_READY
//   EV_OLD    out  vector before the change   (0 when EV_VALID=0)
//   EV_NEW    out  vector after the change    (0 when EV_VALID=0)
//   EV_DWELL  out  enabled cycles EV_OLD held, saturating (0 when EV_VALID=0)
//   OVF       out  sticky: an event was dropped since reset
//   DROP_CNT  out  saturating count of dropped events
module s444_evt_observer
  import s444_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DCW   = 8
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             IN_EN,
  input  logic [VEC_W-1:0] IN_VEC,
  output logic             EV_VALID,
  input  logic             EV_READY,
  output logic [VEC_W-1:0] EV_OLD,
  output logic [VEC_W-1:0] EV_NEW,
  output logic [DWW-1:0]   EV_DWELL,
  output logic             OVF,
  output logic [DCW-1:0]   DROP_CNT
);

  logic [VEC_W-1:0] cur_q, cur_d;
  logic [DWW-1:0]   dwell_q, dwell_d;
  logic             armed_q, armed_d;
  logic             pend_vld_q, pend_vld_d;
  evt_t             pend_evt_q, pend_evt_d;
  logic             ovf_q, ovf_d;
  logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;
  evt_t             fifo_head;

  assign fifo_pop = EV_READY & ~fifo_empty;
  // A pending event is lost only if the FIFO is full and no slot frees this cycle.
  assign drop     = pend_vld_q & fifo_full & ~fifo_pop;

  // Change detection and dwell tracking; a detected change is parked in a
  // one-entry stage so it reaches the FIFO one edge later.
  always_comb begin
    cur_d      = cur_q;
    dwell_d    = dwell_q;
    armed_d    = armed_q;
    pend_vld_d = 1'b0;
    pend_evt_d = pend_evt_q;
    if (IN_EN) begin
      if (!armed_q) begin
        cur_d   = IN_VEC;
        dwell_d = DWW'(1);
        armed_d = 1'b1;
      end else if (IN_VEC == cur_q) begin
        dwell_d = dwell_inc(dwell_q);
      end else begin
        pend_vld_d = 1'b1;
        pend_evt_d = '{old_v: cur_q, new_v: IN_VEC, dwell: dwell_q};
        cur_d      = IN_VEC;
        dwell_d    = DWW'(1);
      end
    end else begin
      cur_d   = cur_q;
      dwell_d = dwell_q;
      armed_d = armed_q;
    end
  end

  // Overflow flag and saturating drop counter.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != {DCW{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DCW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Observer state registers; reset also discards the pending event.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      cur_q      <= {VEC_W{1'b0}};
      dwell_q    <= {DWW{1'b0}};
      armed_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_evt_q <= evt_t'({EVT_W{1'b0}});
      ovf_q      <= 1'b0;
      drop_cnt_q <= {DCW{1'b0}};
    end else begin
      cur_q      <= cur_d;
      dwell_q    <= dwell_d;
      armed_q    <= armed_d;
      pend_vld_q <= pend_vld_d;
      pend_evt_q <= pend_evt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  s444_evt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CK),
    .rst_n    (RSTN),
    .push     (pend_vld_q),
    .push_data(pend_evt_q),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign EV_VALID = ~fifo_empty;
  assign EV_OLD   = fifo_head.old_v;
  assign EV_NEW   = fifo_head.new_v;
  assign EV_DWELL = fifo_head.dwell;
  assign OVF      = ovf_q;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_s444_evt_observer.sv
// Self-checking bench for s444_evt_observer: a table of vectors for the basic
// change event, hand-written sequences for saturation, overflow, full+pop,
// reset and enable gaps, and a reference queue of expected events popped on
// every accepted handshake.
module tb_s444_evt_observer;
  import s444_evt_pkg::*;

  logic       CK = 1'b0;
  logic       RSTN;
  logic       IN_EN;
  logic [5:0] IN_VEC;
  logic       EV_VALID;
  logic       EV_READY;
  logic [5:0] EV_OLD;
  logic [5:0] EV_NEW;
  logic [3:0] EV_DWELL;
  logic       OVF;
  logic [7:0] DROP_CNT;

  s444_evt_observer #(.DEPTH(4), .DCW(8)) dut (
    .CK(CK), .RSTN(RSTN), .IN_EN(IN_EN), .IN_VEC(IN_VEC),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_OLD(EV_OLD),
    .EV_NEW(EV_NEW), .EV_DWELL(EV_DWELL), .OVF(OVF), .DROP_CNT(DROP_CNT)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Reference state
  evt_t       mq[$];
  logic       m_pv = 1'b0;
  evt_t       m_pe;
  logic       m_armed = 1'b0;
  logic [5:0] m_cur = 6'h00;
  logic [3:0] m_dwell = 4'h0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_dcnt = 8'h00;

  typedef struct {
    logic       en;
    logic [5:0] vec;
    logic       rdy;
    logic       valid;
    logic [5:0] old_v;
    logic [5:0] new_v;
    logic [3:0] dwell;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs just applied.
  task automatic model_edge();
    logic pop;
    logic full;
    if (!RSTN) begin
      mq.delete();
      m_pv = 1'b0; m_armed = 1'b0; m_cur = 6'h00; m_dwell = 4'h0;
      m_ovf = 1'b0; m_dcnt = 8'h00;
    end else begin
      pop  = (mq.size() != 0) && EV_READY;
      full = (mq.size() == 4);
      if (pop) void'(mq.pop_front());
      if (m_pv) begin
        if (full && !pop) begin
          m_ovf = 1'b1;
          if (m_dcnt != 8'hFF) m_dcnt = m_dcnt + 8'h01;
        end else begin
          mq.push_back(m_pe);
        end
      end
      m_pv = 1'b0;
      if (IN_EN) begin
        if (!m_armed) begin
          m_armed = 1'b1; m_cur = IN_VEC; m_dwell = 4'h1;
        end else if (IN_VEC == m_cur) begin
          if (m_dwell != 4'hF) m_dwell = m_dwell + 4'h1;
        end else begin
          m_pv = 1'b1;
          m_pe = {m_cur, IN_VEC, m_dwell};
          m_cur = IN_VEC; m_dwell = 4'h1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ev_valid", EV_VALID, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ev_old", EV_OLD, mq[0].old_v);
      chk("ev_new", EV_NEW, mq[0].new_v);
      chk("ev_dwell", EV_DWELL, mq[0].dwell);
    end else begin
      chk("ev_zero", {EV_OLD, EV_NEW, EV_DWELL}, 32'h0);
    end
    chk("ovf", OVF, m_ovf);
    chk("drop_cnt", DROP_CNT, m_dcnt);
  endtask

  // Apply inputs, clock once, update the reference, check on the falling edge.
  task automatic step(input logic rstn, input logic en, input logic [5:0] vec, input logic rdy);
    RSTN = rstn; IN_EN = en; IN_VEC = vec; EV_READY = rdy;
    @(posedge CK);
    model_edge();
    @(negedge CK);
    check_outputs();
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 6'h05, 1'b1, 1'b0, 6'h00, 6'h00, 4'h0};
    tbl[1] = '{1'b1, 6'h05, 1'b1, 1'b0, 6'h00, 6'h00, 4'h0};
    tbl[2] = '{1'b1, 6'h05, 1'b1, 1'b0, 6'h00, 6'h00, 4'h0};
    tbl[3] = '{1'b1, 6'h0A, 1'b1, 1'b0, 6'h00, 6'h00, 4'h0};
    tbl[4] = '{1'b1, 6'h0A, 1'b1, 1'b1, 6'h05, 6'h0A, 4'h3};
    tbl[5] = '{1'b1, 6'h0A, 1'b1, 1'b0, 6'h00, 6'h00, 4'h0};

    // 1: reset with all-ones input
    step(1'b0, 1'b1, 6'h3F, 1'b0);
    step(1'b0, 1'b1, 6'h3F, 1'b0);
    chk("t1_valid", EV_VALID, 1'b0);
    chk("t1_ovf", OVF, 1'b0);
    chk("t1_drop", DROP_CNT, 8'h00);

    // 2: 05 held three samples then 0A, consumer always ready
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].en, tbl[i].vec, tbl[i].rdy);
      chk($sformatf("t2_valid[%0d]", i), EV_VALID, tbl[i].valid);
      chk($sformatf("t2_old[%0d]", i), EV_OLD, tbl[i].old_v);
      chk($sformatf("t2_new[%0d]", i), EV_NEW, tbl[i].new_v);
      chk($sformatf("t2_dwell[%0d]", i), EV_DWELL, tbl[i].dwell);
    end

    // 3: dwell saturation
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 6'h11, 1'b1);
    step(1'b1, 1'b1, 6'h22, 1'b1);
    step(1'b1, 1'b0, 6'h22, 1'b1);
    chk("t3_valid", EV_VALID, 1'b1);
    chk("t3_new", EV_NEW, 6'h22);
    chk("t3_dwell_sat", EV_DWELL, 4'hF);
    step(1'b1, 1'b0, 6'h22, 1'b1);

    // 4: five changes with consumer stalled -> four kept, one dropped
    step(1'b1, 1'b1, 6'h01, 1'b0);
    step(1'b1, 1'b1, 6'h02, 1'b0);
    step(1'b1, 1'b1, 6'h03, 1'b0);
    step(1'b1, 1'b1, 6'h04, 1'b0);
    step(1'b1, 1'b1, 6'h05, 1'b0);
    step(1'b1, 1'b0, 6'h05, 1'b0);
    step(1'b1, 1'b0, 6'h05, 1'b0);
    chk("t4_ovf", OVF, 1'b1);
    chk("t4_drop", DROP_CNT, 8'h01);
    chk("t4_head_old", EV_OLD, 6'h22);
    chk("t4_head_new", EV_NEW, 6'h01);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (EV_VALID) n++;
      step(1'b1, 1'b0, 6'h05, 1'b1);
    end
    chk("t4_drained", n, 4);
    chk("t4_empty", EV_VALID, 1'b0);

    // 5: full FIFO, new event arrives in the same cycle as a pop
    step(1'b1, 1'b1, 6'h06, 1'b0);
    step(1'b1, 1'b1, 6'h07, 1'b0);
    step(1'b1, 1'b1, 6'h08, 1'b0);
    step(1'b1, 1'b1, 6'h09, 1'b0);
    step(1'b1, 1'b0, 6'h09, 1'b0);
    step(1'b1, 1'b1, 6'h0A, 1'b0);
    step(1'b1, 1'b0, 6'h0A, 1'b1);
    chk("t5_drop_same", DROP_CNT, 8'h01);
    chk("t5_head_old", EV_OLD, 6'h06);
    step(1'b1, 1'b0, 6'h0A, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (EV_VALID) n++;
      step(1'b1, 1'b0, 6'h0A, 1'b1);
    end
    chk("t5_remaining", n, 4);

    // 6: reset discards queued events, re-arm, enable gap keeps dwell
    step(1'b1, 1'b1, 6'h0B, 1'b0);
    step(1'b1, 1'b1, 6'h0C, 1'b0);
    step(1'b1, 1'b0, 6'h0C, 1'b0);
    chk("t6_queued", EV_VALID, 1'b1);
    step(1'b0, 1'b1, 6'h0D, 1'b1);
    chk("t6_rst_valid", EV_VALID, 1'b0);
    chk("t6_rst_ovf", OVF, 1'b0);
    chk("t6_rst_drop", DROP_CNT, 8'h00);
    step(1'b1, 1'b1, 6'h0D, 1'b1);
    step(1'b1, 1'b0, 6'h0D, 1'b1);
    chk("t6_rearm_only", EV_VALID, 1'b0);
    step(1'b1, 1'b1, 6'h0D, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'h3F, 1'b1);
    step(1'b1, 1'b1, 6'h0D, 1'b1);
    step(1'b1, 1'b1, 6'h0E, 1'b0);
    step(1'b1, 1'b0, 6'h0E, 1'b0);
    chk("t6_gap_valid", EV_VALID, 1'b1);
    chk("t6_gap_old", EV_OLD, 6'h0D);
    chk("t6_gap_new", EV_NEW, 6'h0E);
    chk("t6_gap_dwell", EV_DWELL, 4'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
